// File: rtl/mmio_timer_responder_pkg.sv
// Shared constants for the memory-mapped timer: register offsets,
// CTRL bit positions and the 2-bit run-state encoding.
package mmio_timer_responder_pkg;

    localparam logic [4:0] OFS_CTRL    = 5'h00;
    localparam logic [4:0] OFS_COUNT   = 5'h04;
    localparam logic [4:0] OFS_COMPARE = 5'h08;
    localparam logic [4:0] OFS_STATUS  = 5'h0C;
    localparam logic [4:0] OFS_PRESC   = 5'h10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_AR     = 2;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } timer_state_e;

endpackage

// File: rtl/mmio_timer_responder_prescaler.sv
// Programmable divider: tick is high for one cycle every div+1 cycles
// after the last clear.
module timer_prescaler #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [W-1:0] div,
    output logic         tick
);

    logic [W-1:0] cnt_q;

    assign tick = (cnt_q == div);

    // Count up to div, then restart; clear restarts the period.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/mmio_timer_responder.sv
// Memory-mapped timer with compare match interrupt and one-cycle reads.
// Optional prescaler enabled by defining TIMER_PRESCALER_EN.
module mmio_timer_responder
    import mmio_timer_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_FF00,
    parameter int          PRESC_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        mem_w,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);

    timer_state_e state_q;
    timer_state_e state_d;

    logic [2:0]  ctrl_q;
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        match_q;

    logic        in_win;
    logic [2:0]  word;
    logic        wr;
    logic        wr_ctrl;
    logic        wr_count;
    logic        wr_cmp;
    logic        wr_status;
    logic        running;
    logic        tick;
    logic        step;
    logic        cmp_eq;
    logic        set_match;
    logic [31:0] rd_val;
    logic        unused_addr_bits;

    assign in_win    = (addr[31:5] == BASE_ADDR[31:5]);
    assign word      = addr[4:2];
    assign wr        = mem_w & in_win;
    assign wr_ctrl   = wr & (word == OFS_CTRL[4:2]);
    assign wr_count  = wr & (word == OFS_COUNT[4:2]);
    assign wr_cmp    = wr & (word == OFS_COMPARE[4:2]);
    assign wr_status = wr & (word == OFS_STATUS[4:2]);

    // Byte lanes are ignored: misaligned accesses act as aligned.
    assign unused_addr_bits = ^addr[1:0];

    assign cmp_eq    = (count_q == compare_q);
    assign step      = running & tick;
    assign set_match = step & cmp_eq;

`ifdef TIMER_PRESCALER_EN
    logic [PRESC_W-1:0] presc_q;
    logic               wr_presc;
    logic               presc_clear;

    assign wr_presc    = wr & (word == OFS_PRESC[4:2]);
    // Divider restarts whenever the timer is not running, so it is
    // fresh on entry to RUN, and whenever the period is reprogrammed.
    assign presc_clear = ~running | wr_presc;

    // Prescale period register.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
        end else if (wr_presc) begin
            presc_q <= wdata[PRESC_W-1:0];
        end
    end

    timer_prescaler #(
        .W(PRESC_W)
    ) u_presc (
        .clk  (clk),
        .reset(reset),
        .clear(presc_clear),
        .div  (presc_q),
        .tick (tick)
    );
`else
    logic [PRESC_W-1:0] presc_q;

    assign presc_q = '0;
    assign tick    = 1'b1;
`endif

    // Run-state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // Run-state transitions; a CTRL write outranks a match in RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STOP: begin
                if (wr_ctrl && wdata[CTRL_EN]) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wr_ctrl && !wdata[CTRL_EN]) begin
                    state_d = ST_STOP;
                end else if (set_match && !ctrl_q[CTRL_AR]) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (wr_ctrl) begin
                    state_d = wdata[CTRL_EN] ? ST_RUN : ST_STOP;
                end else if (wr_count) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_STOP;
        endcase
    end

    // Decoded run-state outputs.
    always_comb begin
        running = 1'b0;
        if (state_q == ST_RUN) begin
            running = 1'b1;
        end
    end

    // Register file; CPU writes to COUNT beat the timer's own update,
    // and a fresh match beats a write-1-to-clear of STATUS.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= '0;
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            match_q   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_q <= wdata[2:0];
            end
            if (wr_count) begin
                count_q <= wdata;
            end else if (step) begin
                if (cmp_eq) begin
                    if (ctrl_q[CTRL_AR]) begin
                        count_q <= '0;
                    end
                end else begin
                    count_q <= count_q + 32'd1;
                end
            end
            if (wr_cmp) begin
                compare_q <= wdata;
            end
            if (set_match) begin
                match_q <= 1'b1;
            end else if (wr_status && wdata[0]) begin
                match_q <= 1'b0;
            end
        end
    end

    // Read mux over current (pre-update) register values.
    always_comb begin
        rd_val = '0;
        case (word)
            OFS_CTRL[4:2]:    rd_val = {29'd0, ctrl_q};
            OFS_COUNT[4:2]:   rd_val = count_q;
            OFS_COMPARE[4:2]: rd_val = compare_q;
            OFS_STATUS[4:2]:  rd_val = {31'd0, match_q};
            OFS_PRESC[4:2]:   rd_val = 32'(presc_q);
            default:          rd_val = '0;
        endcase
    end

    // Registered bus response and interrupt level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
            hit   <= 1'b0;
            irq   <= 1'b0;
        end else begin
            rdata <= in_win ? rd_val : 32'd0;
            hit   <= in_win;
            irq   <= match_q & ctrl_q[CTRL_IRQ_EN];
        end
    end

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Directed self-checking bench for mmio_timer_responder.
// Covers reads, one-shot, auto-reload, wrap, priorities and 0x10.
module tb_mmio_timer_responder;

    localparam logic [31:0] BASE      = 32'h0000_FF00;
    localparam logic [31:0] A_CTRL    = BASE + 32'h00;
    localparam logic [31:0] A_COUNT   = BASE + 32'h04;
    localparam logic [31:0] A_COMPARE = BASE + 32'h08;
    localparam logic [31:0] A_STATUS  = BASE + 32'h0C;
    localparam logic [31:0] A_PRESC   = BASE + 32'h10;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        mem_w;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    int n_checks;
    int n_fail;

    logic [31:0] d;
    logic        h;

    mmio_timer_responder #(
        .BASE_ADDR(BASE),
        .PRESC_W  (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .mem_w(mem_w),
        .wdata(wdata),
        .rdata(rdata),
        .hit  (hit),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_w = 1'b0;
        addr  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        addr  = a;
        wdata = v;
        mem_w = 1'b1;
        @(posedge clk);
        #1;
        mem_w = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a,
                      output logic [31:0] v,
                      output logic hv);
        @(negedge clk);
        addr  = a;
        mem_w = 1'b0;
        @(posedge clk);
        #1;
        v  = rdata;
        hv = hit;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (rdata !== 32'h0 || hit !== 1'b0 || irq !== 1'b0) begin
            $display("FAIL reset_outputs: rdata=%h hit=%b irq=%b want 0/0/0",
                     rdata, hit, irq);
            n_fail++;
        end
        rd(A_COMPARE, d, h);
        n_checks++;
        if (d !== 32'hFFFF_FFFF || h !== 1'b1) begin
            $display("FAIL reset_compare: got %h hit=%b want ffffffff hit=1",
                     d, h);
            n_fail++;
        end
        rd(32'h0, d, h);
        n_checks++;
        if (d !== 32'h0 || h !== 1'b0) begin
            $display("FAIL outside_read: got %h hit=%b want 0 hit=0", d, h);
            n_fail++;
        end
        rd(A_COUNT, d, h);
        n_checks++;
        if (d !== 32'h0) begin
            $display("FAIL reset_count: got %h want 0", d);
            n_fail++;
        end
    endtask

    task automatic test_decode();
        do_reset();
        wr(32'h0000_FE08, 32'h7);
        wr(32'h0001_FF08, 32'h8);
        rd(A_COMPARE + 32'h3, d, h);
        n_checks++;
        if (d !== 32'hFFFF_FFFF || h !== 1'b1) begin
            $display("FAIL out_of_window_write: got %h hit=%b want ffffffff",
                     d, h);
            n_fail++;
        end
        wr(A_CTRL, 32'hFFFF_FFF8);
        rd(A_CTRL, d, h);
        n_checks++;
        if (d !== 32'h0) begin
            $display("FAIL ctrl_upper_bits: got %h want 0", d);
            n_fail++;
        end
        wr(BASE + 32'h14, 32'hABCD);
        rd(BASE + 32'h14, d, h);
        n_checks++;
        if (d !== 32'h0 || h !== 1'b1) begin
            $display("FAIL unmapped_0x14: got %h hit=%b want 0 hit=1", d, h);
            n_fail++;
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] e [$];
        e = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd5};
        do_reset();
        wr(A_COMPARE, 32'd5);
        wr(A_CTRL, 32'd3);
        for (int i = 0; i < 7; i++) begin
            rd(A_COUNT, d, h);
            n_checks++;
            if (d !== e[i]) begin
                $display("FAIL one_shot_count[%0d]: got %0d want %0d",
                         i, d, e[i]);
                n_fail++;
            end
            if (i == 5) begin
                n_checks++;
                if (irq !== 1'b0) begin
                    $display("FAIL one_shot_irq_early: got %b want 0", irq);
                    n_fail++;
                end
            end
        end
        n_checks++;
        if (irq !== 1'b1) begin
            $display("FAIL one_shot_irq: got %b want 1", irq);
            n_fail++;
        end
        rd(A_STATUS, d, h);
        n_checks++;
        if (d !== 32'h1) begin
            $display("FAIL one_shot_match: got %h want 1", d);
            n_fail++;
        end
        repeat (3) rd(A_COUNT, d, h);
        n_checks++;
        if (d !== 32'd5) begin
            $display("FAIL halt_hold: got %0d want 5", d);
            n_fail++;
        end
    endtask

    task automatic test_auto_reload();
        logic [31:0] e [$];
        e = '{32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2};
        do_reset();
        wr(A_COMPARE, 32'd2);
        wr(A_CTRL, 32'd7);
        for (int i = 0; i < 6; i++) begin
            rd(A_COUNT, d, h);
            n_checks++;
            if (d !== e[i]) begin
                $display("FAIL reload_count[%0d]: got %0d want %0d",
                         i, d, e[i]);
                n_fail++;
            end
        end
        rd(A_STATUS, d, h);
        n_checks++;
        if (d !== 32'h1 || irq !== 1'b1) begin
            $display("FAIL reload_match_irq: status=%h irq=%b want 1/1",
                     d, irq);
            n_fail++;
        end
        wr(A_CTRL, 32'd5);
        n_checks++;
        if (irq !== 1'b1) begin
            $display("FAIL irq_en_drop_early: got %b want 1", irq);
            n_fail++;
        end
        rd(A_STATUS, d, h);
        n_checks++;
        if (irq !== 1'b0) begin
            $display("FAIL irq_en_drop: got %b want 0", irq);
            n_fail++;
        end
        wr(A_CTRL, 32'd0);
        wr(A_STATUS, 32'd1);
        rd(A_STATUS, d, h);
        n_checks++;
        if (d !== 32'h0) begin
            $display("FAIL status_clear: got %h want 0", d);
            n_fail++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        wr(A_COUNT, 32'hFFFF_FFFE);
        wr(A_COMPARE, 32'd3);
        wr(A_CTRL, 32'd1);
        rd(A_COUNT, d, h);
        rd(A_COUNT, d, h);
        n_checks++;
        if (d !== 32'hFFFF_FFFF) begin
            $display("FAIL wrap_pre: got %h want ffffffff", d);
            n_fail++;
        end
        rd(A_COUNT, d, h);
        n_checks++;
        if (d !== 32'h0) begin
            $display("FAIL wrap_zero: got %h want 0", d);
            n_fail++;
        end
        rd(A_STATUS, d, h);
        n_checks++;
        if (d !== 32'h0) begin
            $display("FAIL wrap_no_match: got %h want 0", d);
            n_fail++;
        end
        rd(A_COUNT, d, h);
        rd(A_COUNT, d, h);
        rd(A_STATUS, d, h);
        n_checks++;
        if (d !== 32'h1) begin
            $display("FAIL wrap_match_at_3: got %h want 1", d);
            n_fail++;
        end
        rd(A_COUNT, d, h);
        n_checks++;
        if (d !== 32'd3) begin
            $display("FAIL wrap_hold: got %0d want 3", d);
            n_fail++;
        end
    endtask

    task automatic test_priority();
        do_reset();
        wr(A_COMPARE, 32'd3);
        wr(A_CTRL, 32'd1);
        repeat (3) rd(A_COUNT, d, h);
        wr(A_STATUS, 32'd1);
        rd(A_STATUS, d, h);
        n_checks++;
        if (d !== 32'h1) begin
            $display("FAIL match_beats_clear: got %h want 1", d);
            n_fail++;
        end
        wr(A_STATUS, 32'd1);
        rd(A_STATUS, d, h);
        n_checks++;
        if (d !== 32'h0) begin
            $display("FAIL clear_in_halt: got %h want 0", d);
            n_fail++;
        end
        do_reset();
        wr(A_COMPARE, 32'd1000);
        wr(A_CTRL, 32'd1);
        rd(A_COUNT, d, h);
        rd(A_COUNT, d, h);
        wr(A_COUNT, 32'd100);
        rd(A_COUNT, d, h);
        n_checks++;
        if (d !== 32'd100) begin
            $display("FAIL count_write_first: got %0d want 100", d);
            n_fail++;
        end
        rd(A_COUNT, d, h);
        n_checks++;
        if (d !== 32'd101) begin
            $display("FAIL count_write_next: got %0d want 101", d);
            n_fail++;
        end
    endtask

    task automatic test_reset_override();
        do_reset();
        wr(A_COMPARE, 32'd77);
        @(negedge clk);
        reset = 1'b1;
        addr  = A_COMPARE;
        wdata = 32'd9;
        mem_w = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_w = 1'b0;
        rd(A_COMPARE, d, h);
        n_checks++;
        if (d !== 32'hFFFF_FFFF) begin
            $display("FAIL reset_beats_write: got %h want ffffffff", d);
            n_fail++;
        end
    endtask

    task automatic test_prescale();
        do_reset();
        wr(A_PRESC, 32'hFF);
        rd(A_PRESC, d, h);
`ifdef TIMER_PRESCALER_EN
        n_checks++;
        if (d !== 32'hFF) begin
            $display("FAIL presc_rw: got %h want ff", d);
            n_fail++;
        end
        wr(A_PRESC, 32'hFFFF_FF03);
        rd(A_PRESC, d, h);
        n_checks++;
        if (d !== 32'h3) begin
            $display("FAIL presc_width: got %h want 3", d);
            n_fail++;
        end
        wr(A_CTRL, 32'd1);
        for (int i = 0; i < 9; i++) begin
            rd(A_COUNT, d, h);
            n_checks++;
            if (d !== 32'(i / 4)) begin
                $display("FAIL presc_count[%0d]: got %0d want %0d",
                         i, d, i / 4);
                n_fail++;
            end
        end
`else
        n_checks++;
        if (d !== 32'h0) begin
            $display("FAIL no_presc_0x10: got %h want 0", d);
            n_fail++;
        end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        addr     = 32'h0;
        mem_w    = 1'b0;
        wdata    = 32'h0;
        test_reset();
        test_decode();
        test_one_shot();
        test_auto_reload();
        test_wrap();
        test_priority();
        test_reset_override();
        test_prescale();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
